// File: rtl/lii_pkg.sv
// Shared LII definitions: ID width, default beat width, reserved IDs and
// the beats-per-word helper used to size the gather buffer.
package lii_pkg;

    localparam int LII_IDW        = 8;
    localparam int LII_PW_DEFAULT = 64;

    localparam logic [LII_IDW-1:0] LII_ID_BCAST = 8'hFF;
    localparam logic [LII_IDW-1:0] LII_ID_RSVD  = 8'hFE;

    // Returns OW/PW, or 0 when OW is not a whole number of beats so callers can reject it.
    function automatic int nbeats(input int ow, input int pw);
        if ((pw <= 0) || ((ow % pw) != 0)) begin
            return 0;
        end else begin
            return ow / pw;
        end
    endfunction

endpackage

// File: rtl/lii_out_reg.sv
// Single-entry registered AXI-Stream output stage carrying data plus source ID.
// A load in the same cycle as a drain replaces the word without a bubble.
module lii_out_reg
    import lii_pkg::*;
#(
    parameter int DW = 384
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [DW-1:0]      i_data,
    input  logic [LII_IDW-1:0] i_src,
    input  logic               i_tready,
    output logic               o_tvalid,
    output logic [DW-1:0]      o_tdata,
    output logic [LII_IDW-1:0] o_src,
    output logic               o_drain
);

    logic               r_tvalid;
    logic [DW-1:0]      r_tdata;
    logic [LII_IDW-1:0] r_src;

    assign o_drain  = r_tvalid & i_tready;
    assign o_tvalid = r_tvalid;
    assign o_tdata  = r_tdata;
    assign o_src    = r_src;

    // Output holding register: load wins over drain, otherwise hold until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tvalid <= 1'b0;
            r_tdata  <= {DW{1'b0}};
            r_src    <= {LII_IDW{1'b0}};
        end else if (i_load) begin
            r_tvalid <= 1'b1;
            r_tdata  <= i_data;
            r_src    <= i_src;
        end else if (o_drain) begin
            r_tvalid <= 1'b0;
        end else begin
            r_tvalid <= r_tvalid;
        end
    end

endmodule

// File: rtl/lii_gather.sv
// Gathers NB consecutive LII beats into one wide word with destination
// filtering, single-source-per-frame enforcement and drop/frame counters.
module lii_gather
    import lii_pkg::*;
#(
    parameter int                 PW        = LII_PW_DEFAULT,
    parameter int                 OW        = 384,
    parameter logic [LII_IDW-1:0] MY_ID     = 8'h00,
    parameter bit                 CHECK_DST = 1'b1,
    parameter int                 CW        = 16
) (
    input  logic               aclk,
    input  logic               arst,
    input  logic [PW-1:0]      s_tdata,
    input  logic               s_tvalid,
    output logic               s_tready,
    input  logic [LII_IDW-1:0] s_src,
    input  logic [LII_IDW-1:0] s_dst,
    output logic [OW-1:0]      m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic [LII_IDW-1:0] m_src,
    output logic               err_src,
    output logic               err_dst,
    output logic [CW-1:0]      frame_cnt,
    output logic [CW-1:0]      drop_cnt
);

    localparam int NB   = nbeats(OW, PW);
    localparam int CNTW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(NB - 1);

    generate
        if (NB < 2) begin : g_bad_cfg
            $error("lii_gather: OW must be a multiple of PW with at least two beats per word");
        end
    endgenerate

    logic [CNTW-1:0]    r_cnt;
    logic [PW-1:0]      r_buf [NB-1];
    logic [LII_IDW-1:0] r_frame_src;
    logic               r_err_src;
    logic               r_err_dst;
    logic [CW-1:0]      r_frame_cnt;
    logic [CW-1:0]      r_drop_cnt;

    logic               w_m_tvalid;
    logic               w_drain;
    logic               w_acc;
    logic               w_dst_bad;
    logic               w_keep;
    logic               w_drop;
    logic               w_src_err;
    logic               w_final;
    logic [CNTW-1:0]    w_idx;
    logic [OW-1:0]      w_load_data;
    logic [CW:0]        w_drop_inc;
    logic [CW:0]        w_drop_sum;

    // Only the final beat can stall: it needs the output register free or draining.
    assign s_tready   = !arst && !((r_cnt == LAST) && w_m_tvalid && !m_tready);
    assign w_acc      = s_tvalid && s_tready;
    assign w_dst_bad  = (CHECK_DST != 1'b0) && (s_dst != MY_ID);
    assign w_drop     = w_acc && w_dst_bad;
    assign w_keep     = w_acc && !w_dst_bad;
    assign w_src_err  = w_keep && (r_cnt != {CNTW{1'b0}}) && (s_src != r_frame_src);
    assign w_final    = w_keep && !w_src_err && (r_cnt == LAST);
    assign w_idx      = w_src_err ? {CNTW{1'b0}} : r_cnt;

    assign w_drop_inc = w_src_err ? (CW+1)'(r_cnt) :
                        w_drop    ? {{CW{1'b0}}, 1'b1} : {(CW+1){1'b0}};
    assign w_drop_sum = {1'b0, r_drop_cnt} + w_drop_inc;

    // Final word: current beat on top, buffered beats below with beat 0 in the LSBs.
    always_comb begin
        w_load_data = {OW{1'b0}};
        w_load_data[OW-1 -: PW] = s_tdata;
        for (int i = 0; i < NB - 1; i++) begin
            w_load_data[i*PW +: PW] = r_buf[i];
        end
    end

    // Beat counter, partial-frame buffer and frame source latch.
    always_ff @(posedge aclk) begin
        if (arst) begin
            r_cnt       <= {CNTW{1'b0}};
            r_frame_src <= {LII_IDW{1'b0}};
            for (int i = 0; i < NB - 1; i++) begin
                r_buf[i] <= {PW{1'b0}};
            end
        end else if (w_final) begin
            r_cnt <= {CNTW{1'b0}};
        end else if (w_keep) begin
            for (int i = 0; i < NB - 1; i++) begin
                if (w_idx == CNTW'(i)) begin
                    r_buf[i] <= s_tdata;
                end else begin
                    r_buf[i] <= r_buf[i];
                end
            end
            // A source change restarts the frame with the offending beat as beat 0.
            if (w_idx == {CNTW{1'b0}}) begin
                r_frame_src <= s_src;
            end else begin
                r_frame_src <= r_frame_src;
            end
            r_cnt <= w_idx + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Error pulses and status counters (frame wraps, drop saturates).
    always_ff @(posedge aclk) begin
        if (arst) begin
            r_err_src   <= 1'b0;
            r_err_dst   <= 1'b0;
            r_frame_cnt <= {CW{1'b0}};
            r_drop_cnt  <= {CW{1'b0}};
        end else begin
            r_err_src   <= w_src_err;
            r_err_dst   <= w_drop;
            r_frame_cnt <= r_frame_cnt + {{(CW-1){1'b0}}, w_drain};
            r_drop_cnt  <= w_drop_sum[CW] ? {CW{1'b1}} : w_drop_sum[CW-1:0];
        end
    end

    lii_out_reg #(
        .DW(OW)
    ) u_out (
        .clk      (aclk),
        .rst      (arst),
        .i_load   (w_final),
        .i_data   (w_load_data),
        .i_src    (r_frame_src),
        .i_tready (m_tready),
        .o_tvalid (w_m_tvalid),
        .o_tdata  (m_tdata),
        .o_src    (m_src),
        .o_drain  (w_drain)
    );

    assign m_tvalid  = w_m_tvalid;
    assign err_src   = r_err_src;
    assign err_dst   = r_err_dst;
    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_lii_gather.sv
// Scoreboard bench for lii_gather: a beat-queue reference model predicts words,
// ready and counters; a separate monitor compares delivered words.
module tb_lii_gather;
    import lii_pkg::*;

    localparam int PW = 64;
    localparam int OW = 384;
    localparam int NB = 6;
    localparam logic [7:0] MY_ID = 8'h00;
    localparam logic [7:0] BAD_ID = 8'h01;

    logic          aclk = 1'b0;
    logic          arst = 1'b1;
    logic [PW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [7:0]    s_src = '0;
    logic [7:0]    s_dst = '0;
    logic [OW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [7:0]    m_src;
    logic          err_src, err_dst;
    logic [15:0]   frame_cnt, drop_cnt;

    logic          s_tready4, m_tvalid4, err_src4, err_dst4;
    logic [OW-1:0] m_tdata4;
    logic [7:0]    m_src4;
    logic [3:0]    frame_cnt4, drop_cnt4;

    always #5 aclk = ~aclk;

    lii_gather #(.PW(PW), .OW(OW), .MY_ID(MY_ID), .CHECK_DST(1'b1), .CW(16)) u_dut (
        .aclk(aclk), .arst(arst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_src(s_src), .s_dst(s_dst), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_src(m_src), .err_src(err_src), .err_dst(err_dst), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt));

    lii_gather #(.PW(PW), .OW(OW), .MY_ID(MY_ID), .CHECK_DST(1'b1), .CW(4)) u_dut4 (
        .aclk(aclk), .arst(arst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready4),
        .s_src(s_src), .s_dst(s_dst), .m_tdata(m_tdata4), .m_tvalid(m_tvalid4), .m_tready(m_tready),
        .m_src(m_src4), .err_src(err_src4), .err_dst(err_dst4), .frame_cnt(frame_cnt4), .drop_cnt(drop_cnt4));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [OW-1:0] d;
        logic [7:0]    s;
    } word_t;

    // Reference model state: pending beats of the current frame and expected words.
    logic [PW-1:0] mdl_beats[$];
    logic [7:0]    mdl_fsrc = '0;
    word_t         exp_q[$];
    bit            mdl_full = 1'b0;
    bit            mdl_acc = 1'b0;
    int            mdl_frames = 0, mdl_drops = 0;
    int            exp_edst = 0, exp_esrc = 0, obs_edst = 0, obs_esrc = 0;
    bit            m_rdy, m_drain, m_load;
    word_t         m_w;

    always @(negedge aclk) begin
        if (arst) begin
            chk("s_tready_in_reset", {383'b0, s_tready}, '0);
            mdl_beats.delete();
            exp_q.delete();
            mdl_full = 1'b0;
            mdl_acc = 1'b0;
            mdl_frames = 0; mdl_drops = 0;
            exp_edst = 0; exp_esrc = 0; obs_edst = 0; obs_esrc = 0;
        end else begin
            if (err_dst) obs_edst++;
            if (err_src) obs_esrc++;
            m_rdy = !((mdl_beats.size() == NB - 1) && mdl_full && !m_tready);
            chk("s_tready", {383'b0, s_tready}, {383'b0, m_rdy});
            m_drain = mdl_full && m_tready;
            m_load = 1'b0;
            mdl_acc = s_tvalid && m_rdy;
            if (mdl_acc) begin
                if (s_dst != MY_ID) begin
                    mdl_drops++;
                    exp_edst++;
                end else begin
                    if ((mdl_beats.size() > 0) && (s_src != mdl_fsrc)) begin
                        mdl_drops += mdl_beats.size();
                        exp_esrc++;
                        mdl_beats.delete();
                    end
                    if (mdl_beats.size() == 0) mdl_fsrc = s_src;
                    mdl_beats.push_back(s_tdata);
                    if (mdl_beats.size() == NB) begin
                        m_w.d = '0;
                        for (int k = 0; k < NB; k++) m_w.d[k*PW +: PW] = mdl_beats[k];
                        m_w.s = mdl_fsrc;
                        exp_q.push_back(m_w);
                        mdl_beats.delete();
                        m_load = 1'b1;
                    end
                end
            end
            if (m_drain) mdl_frames++;
            mdl_full = m_load || (mdl_full && !m_tready);
        end
    end

    // Monitor: compares each delivered word against the scoreboard and checks hold-while-stalled.
    bit            hold_v = 1'b0;
    logic [OW-1:0] hold_d;
    logic [7:0]    hold_s;
    word_t         mon_w;

    always @(negedge aclk) begin
        if (arst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_tvalid", {383'b0, m_tvalid}, {383'b0, 1'b1});
                chk("hold_tdata", m_tdata, hold_d);
                chk("hold_src", {376'b0, m_src}, {376'b0, hold_s});
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {383'b0, m_tvalid}, '0);
                end else begin
                    mon_w = exp_q.pop_front();
                    chk("word_data", m_tdata, mon_w.d);
                    chk("word_src", {376'b0, m_src}, {376'b0, mon_w.s});
                end
            end
            hold_v = m_tvalid && !m_tready;
            hold_d = m_tdata;
            hold_s = m_src;
        end
    end

    task automatic check_status(input string tag);
        int d16, d4;
        d16 = (mdl_drops > 65535) ? 65535 : mdl_drops;
        d4  = (mdl_drops > 15) ? 15 : mdl_drops;
        chk({tag, "_frame_cnt"}, {368'b0, frame_cnt}, OW'(mdl_frames % 65536));
        chk({tag, "_drop_cnt"}, {368'b0, drop_cnt}, OW'(d16));
        chk({tag, "_frame_cnt4"}, {380'b0, frame_cnt4}, OW'(mdl_frames % 16));
        chk({tag, "_drop_cnt4"}, {380'b0, drop_cnt4}, OW'(d4));
        chk({tag, "_err_dst_pulses"}, OW'(obs_edst), OW'(exp_edst));
        chk({tag, "_err_src_pulses"}, OW'(obs_esrc), OW'(exp_esrc));
    endtask

    task automatic beat(input logic [PW-1:0] d, input logic [7:0] src, input logic [7:0] dst);
        int  n;
        bit  got;
        n = 0;
        got = 1'b0;
        s_tvalid = 1'b1; s_tdata = d; s_src = src; s_dst = dst;
        while (!got && (n < 50)) begin
            @(posedge aclk);
            got = mdl_acc;
            #1;
            n++;
        end
        if (!got) chk("beat_accept_timeout", {383'b0, got}, {383'b0, 1'b1});
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_m_tvalid", {383'b0, m_tvalid}, '0);
        chk("rst_m_tdata", m_tdata, '0);
        chk("rst_m_src", {376'b0, m_src}, '0);
        chk("rst_err", {382'b0, err_src, err_dst}, '0);
        chk("rst_cnts", {352'b0, frame_cnt, drop_cnt}, '0);
        chk("rst_cnts4", {376'b0, frame_cnt4, drop_cnt4}, '0);
        arst = 1'b0;

        // Basic frame
        for (int i = 1; i <= NB; i++) beat(64'(i), 8'd3, MY_ID);
        idle(3);
        chk("basic_frame_cnt", {368'b0, frame_cnt}, 384'd1);
        check_status("basic");

        // Back-pressure: 11 beats go in, the 12th stalls until the word drains
        m_tready = 1'b0;
        for (int i = 1; i <= 11; i++) beat(64'h100 + 64'(i), 8'd4, MY_ID);
        s_tvalid = 1'b1; s_tdata = 64'h10c; s_src = 8'd4; s_dst = MY_ID;
        repeat (3) begin
            @(posedge aclk);
            #1;
        end
        chk("bp_stall_ready", {383'b0, s_tready}, '0);
        m_tready = 1'b1;
        beat(64'h10c, 8'd4, MY_ID);
        idle(3);
        chk("bp_frame_cnt", {368'b0, frame_cnt}, 384'd3);
        check_status("bp");

        // Destination filter
        for (int i = 0; i < 8; i++)
            beat(64'h200 + 64'(i), 8'd5, ((i == 2) || (i == 5)) ? BAD_ID : MY_ID);
        idle(3);
        check_status("dst");

        // Source mismatch restart
        for (int i = 0; i < 3; i++) beat(64'h300 + 64'(i), 8'd1, MY_ID);
        for (int i = 0; i < NB; i++) beat(64'h400 + 64'(i), 8'd2, MY_ID);
        idle(3);
        check_status("src");

        // Reset mid-frame
        for (int i = 0; i < 4; i++) beat(64'h500 + 64'(i), 8'd6, MY_ID);
        idle(2);
        check_status("pre_rst");
        arst = 1'b1;
        @(posedge aclk);
        #1;
        arst = 1'b0;
        for (int i = 0; i < NB; i++) beat(64'h600 + 64'(i), 8'd7, MY_ID);
        idle(3);
        chk("rst_mid_cnts", {352'b0, frame_cnt, drop_cnt}, {352'b0, 16'd1, 16'd0});
        check_status("rst_mid");

        // Randomized traffic with occasional wrong dst, source changes and stalls
        begin
            logic [7:0] cur_src;
            cur_src = 8'd9;
            for (int c = 0; c < 3000; c++) begin
                if ($urandom_range(15) == 0) cur_src = 8'($urandom_range(3));
                s_tvalid = ($urandom_range(3) != 0);
                s_tdata  = {$urandom, $urandom};
                s_src    = cur_src;
                s_dst    = ($urandom_range(7) == 0) ? BAD_ID : MY_ID;
                m_tready = ($urandom_range(9) < 7);
                @(posedge aclk);
                #1;
            end
        end
        m_tready = 1'b1;
        idle(10);
        check_status("random");
        chk("scoreboard_empty", OW'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lii_gather.md
Name: lii_gather

Overview:
- Upstream neighbour of the fc3 stream wrapper: sits between one LII phy input channel (PW-bit beats tagged with src/dst) and the wide kernel-side input stream (OW bits, 384 for fc3).
- Accumulates NB = OW/PW consecutive PW-bit beats into one OW-bit word, then presents it on a registered AXI-Stream master.
- Filters beats by destination ID, enforces a single source per frame, and keeps drop/frame counters.
- Sustains one input beat per cycle with no bubble between frames.

Parameters:
- PW, 64, LII phy beat width.
- OW, 384, output word width; must be an integer multiple of PW (NB = OW/PW, 6 at defaults).
- MY_ID, 8'h00, destination ID accepted by this stage.
- CHECK_DST, 1, 1 = drop beats with s_dst != MY_ID; 0 = accept all beats.
- CW, 16, width of status counters.

Ports:
- aclk  in  1  clock.
- arst  in  1  synchronous reset, active-high.
- s_tdata  in  PW  LII beat data.
- s_tvalid  in  1  beat valid.
- s_tready  out  1  beat accepted when s_tvalid & s_tready.
- s_src  in  8  source ID of beat.
- s_dst  in  8  destination ID of beat.
- m_tdata  out  OW  assembled word, to kernel in_stream_tdata.
- m_tvalid  out  1  word valid.
- m_tready  in  1  kernel ready.
- m_src  out  8  source ID of the frame in m_tdata.
- err_src  out  1  one-cycle pulse on a source-mismatch restart.
- err_dst  out  1  one-cycle pulse on a dropped (wrong-dst) beat.
- frame_cnt  out  CW  words delivered (m handshakes); wraps modulo 2^CW.
- drop_cnt  out  CW  beats dropped (dst mismatch plus discarded partial beats); saturates at all-ones.

Behaviour:
- Reset (arst=1 at a clock edge):
  - Outputs: m_tvalid=0, m_tdata=0, m_src=0, err_*=0, frame_cnt=0, drop_cnt=0.
  - State: beat index cnt=0, assembly buffer cleared.
  - s_tready is held 0 combinationally while arst=1.
  - Reset mid-frame discards the partial frame without counting it.
- Accept: acc = s_tvalid & s_tready.
- Drop: drop = acc & CHECK_DST & (s_dst != MY_ID). A dropped beat does not touch cnt or the buffer; it pulses err_dst on the next cycle and increments drop_cnt.
- Ready:
  - s_tready = !arst & !(cnt==NB-1 & m_tvalid & !m_tready).
  - s_tready never depends on s_dst, s_src or s_tdata.
- Packing:
  - A kept beat with cnt=k is placed at bits [k*PW +: PW], so beat 0 occupies the LSBs.
  - Beat 0 latches frame_src = s_src.
  - For k < NB-1: buffer[k] <= s_tdata, cnt <= k+1.
- Final beat (kept, cnt==NB-1):
  - m_tdata <= {s_tdata, buffer[NB-2:0]}, m_src <= frame_src, m_tvalid <= 1, cnt <= 0.
  - Latency: m_tvalid rises the cycle after the final-beat handshake.
- Source check:
  - Applies to a kept beat with cnt>0 and s_src != frame_src.
  - The partial frame is discarded and drop_cnt += cnt (saturating).
  - The offending beat becomes beat 0 of a new frame (cnt <= 1, frame_src <= s_src), and err_src pulses.
- Output:
  - m_tvalid/m_tdata/m_src hold stable until m_tvalid & m_tready.
  - On that handshake, frame_cnt increments, and m_tvalid clears unless a new final beat loads in the same cycle.
  - Simultaneous drain and load: the new word replaces the old one, m_tvalid stays 1, no bubble.
- Back-pressure:
  - Beats 0..NB-2 are always accepted while a word is waiting.
  - Only the final beat stalls (output register full, not draining).
- Counters:
  - frame_cnt wraps from 2^CW-1 to 0.
  - drop_cnt sticks at 2^CW-1.
  - Both increments in one cycle (discard plus dst drop cannot coincide) are mutually exclusive by construction.

Decomposition:
- Shared package lii_pkg: LII ID width (8), default PW, the broadcast/reserved ID constants, and a function nbeats(ow,pw) with an elaboration-time check that OW % PW == 0.
- One natural sub-module: lii_out_reg, a single-entry registered AXIS output holding data+src with the load-while-drain rule.
- Assembly counter, buffer and checks stay in lii_gather.

Test Plan:
- Basic frame: 6 beats 64'h1..64'h6, src=3, dst=MY_ID, m_tready=1 → one cycle after beat 6, m_tvalid=1, m_tdata = {6,5,4,3,2,1} (beat 1 in LSBs), m_src=3; frame_cnt=1.
- Back-pressure: m_tready=0, send 12 beats back-to-back → first 11 accepted, s_tready=0 on beat 12. Raise m_tready → word 1 drains, word 2 loads the same cycle, m_tvalid never drops; frame_cnt=2 after drain.
- Dst filter: interleave 2 beats with dst=MY_ID+1 among 6 good beats → err_dst pulses twice, drop_cnt=2, output word equals the 6 good beats only. With CHECK_DST=0 → 8 beats form 1 word plus 2 pending.
- Src mismatch: 3 beats src=1, then 6 beats src=2 → err_src pulses once, drop_cnt=3, single word with m_src=2 containing the last 6 beats.
- Reset mid-frame: 4 beats, arst=1 for one cycle, then 6 new beats → s_tready=0 during reset, exactly one word equal to the new 6 beats, counters=1/0.
- Counter limits: preload via long run (CW=4 build) → frame_cnt wraps 15→0, drop_cnt stops at 15.
